// File: rtl/sa_skew_feeder_pkg.sv
// Shared types and width helpers for the systolic-array skew feeder.
package sa_feed_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam int unsigned DEF_ROW    = 4;
  localparam int unsigned DEF_COL    = 4;
  localparam int unsigned DEF_W_DATA = 8;
  localparam int unsigned DEF_W_ADDR = 4;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Byte counters must hold max(ROW,COL)*MAX_K inclusive.
  function automatic int unsigned cnt_width(input int unsigned row, input int unsigned col,
                                            input int unsigned w_addr);
    return $clog2(max_u(row, col) * (1 << w_addr) + 1);
  endfunction

  // Step counter must hold MAX_K + max(ROW,COL) inclusive.
  function automatic int unsigned step_width(input int unsigned row, input int unsigned col,
                                             input int unsigned w_addr);
    return $clog2((1 << w_addr) + max_u(row, col) + 1);
  endfunction

  function automatic int unsigned ptr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sa_skew_feeder_if.sv
// Byte-stream input, job control and skewed lane outputs of the feeder.
interface sa_skew_feeder_if #(
  parameter int unsigned ROW    = 4,
  parameter int unsigned COL    = 4,
  parameter int unsigned W_DATA = 8,
  parameter int unsigned W_ADDR = 4
) ();

  logic                    i_start;
  logic [W_ADDR:0]         i_k;
  logic                    i_rx_dv;
  logic                    i_sel;
  logic [W_DATA-1:0]       i_data;
  logic                    i_stall;
  logic [COL*W_DATA-1:0]   o_north_data;
  logic [COL-1:0]          o_north_dv;
  logic [ROW*W_DATA-1:0]   o_west_data;
  logic [ROW-1:0]          o_west_dv;
  logic                    o_busy;
  logic                    o_done;
  logic                    o_overflow;
  logic                    o_err;

  modport master (
    output i_start, i_k, i_rx_dv, i_sel, i_data, i_stall,
    input  o_north_data, o_north_dv, o_west_data, o_west_dv,
           o_busy, o_done, o_overflow, o_err
  );

  modport slave (
    input  i_start, i_k, i_rx_dv, i_sel, i_data, i_stall,
    output o_north_data, o_north_dv, o_west_data, o_west_dv,
           o_busy, o_done, o_overflow, o_err
  );

endinterface

// File: rtl/sa_skew_feeder_lane_fifo.sv
// One lane FIFO: synchronous reset, registered read data that is zero when no read.
module sa_lane_fifo #(
  parameter int unsigned W_DATA = 8,
  parameter int unsigned W_ADDR = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_wr,
  input  logic [W_DATA-1:0] i_wdata,
  input  logic              i_rd,
  output logic [W_DATA-1:0] o_rdata,
  output logic              o_rvalid
);

  localparam int unsigned DEPTH = 1 << W_ADDR;
  localparam int unsigned CW    = W_ADDR + 1;

  logic [W_DATA-1:0] mem_q [DEPTH];
  logic [W_ADDR-1:0] wptr_q, wptr_d;
  logic [W_ADDR-1:0] rptr_q, rptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [W_DATA-1:0] rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;
  logic              do_wr, do_rd;

  // Full/empty guards keep pointers sane even if a caller misbehaves.
  always_comb begin
    do_wr    = i_wr && (cnt_q != CW'(DEPTH));
    do_rd    = i_rd && (cnt_q != '0);
    wptr_d   = do_wr ? wptr_q + W_ADDR'(1) : wptr_q;
    rptr_d   = do_rd ? rptr_q + W_ADDR'(1) : rptr_q;
    cnt_d    = cnt_q + CW'(do_wr) - CW'(do_rd);
    rdata_d  = do_rd ? mem_q[rptr_q] : '0;
    rvalid_d = do_rd;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      cnt_q    <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_wr) mem_q[wptr_q] <= i_wdata;
  end

  assign o_rdata  = rdata_q;
  assign o_rvalid = rvalid_q;

endmodule

// File: rtl/sa_skew_feeder.sv
// Demuxes the UART byte stream into north/west lanes and replays them with wavefront skew.
module sa_skew_feeder
  import sa_feed_pkg::*;
#(
  parameter int unsigned ROW    = DEF_ROW,
  parameter int unsigned COL    = DEF_COL,
  parameter int unsigned W_DATA = DEF_W_DATA,
  parameter int unsigned W_ADDR = DEF_W_ADDR
) (
  input logic               i_clk,
  input logic               i_rst,
  sa_skew_feeder_if.slave   bus
);

  localparam int unsigned MAX_K = 1 << W_ADDR;
  localparam int unsigned KW    = W_ADDR + 1;
  localparam int unsigned CNT_W = cnt_width(ROW, COL, W_ADDR);
  localparam int unsigned T_W   = step_width(ROW, COL, W_ADDR);
  localparam int unsigned NPW   = ptr_width(COL);
  localparam int unsigned RPW   = ptr_width(ROW);
  localparam int unsigned LANES = max_u(ROW, COL);

  state_e           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic [CNT_W-1:0] w_cnt_q, w_cnt_d, r_cnt_q, r_cnt_d;
  logic [NPW-1:0]   w_lane_q, w_lane_d;
  logic [RPW-1:0]   r_lane_q, r_lane_d;
  logic [T_W-1:0]   t_q, t_d;
  logic             overflow_q, overflow_d;
  logic             err_q, err_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  logic [COL-1:0]   north_wr, north_rd, north_sel, north_win;
  logic [ROW-1:0]   west_wr, west_rd, west_sel, west_win;
  logic [T_W-1:0]   k_t, t_last;
  logic [CNT_W-1:0] w_total, r_total;
  logic             w_full, r_full, k_legal;

  // Lane select decode and diagonal read windows.
  always_comb begin
    k_t     = T_W'(k_q);
    t_last  = k_t + T_W'(LANES) - T_W'(2);
    w_total = CNT_W'(COL) * CNT_W'(k_q);
    r_total = CNT_W'(ROW) * CNT_W'(k_q);
    w_full  = (w_cnt_q == w_total);
    r_full  = (r_cnt_q == r_total);
    k_legal = (bus.i_k != '0) && (bus.i_k <= KW'(MAX_K));
    for (int j = 0; j < COL; j++) begin
      north_sel[j] = (w_lane_q == NPW'(j));
      north_win[j] = (t_q >= T_W'(j)) && (t_q < T_W'(j) + k_t);
    end
    for (int i = 0; i < ROW; i++) begin
      west_sel[i] = (r_lane_q == RPW'(i));
      west_win[i] = (t_q >= T_W'(i)) && (t_q < T_W'(i) + k_t);
    end
  end

  // Next-state and control.
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    w_cnt_d    = w_cnt_q;
    r_cnt_d    = r_cnt_q;
    w_lane_d   = w_lane_q;
    r_lane_d   = r_lane_q;
    t_d        = t_q;
    overflow_d = overflow_q;
    err_d      = 1'b0;
    done_d     = (state_q == ST_DONE);
    north_wr   = '0;
    west_wr    = '0;
    north_rd   = '0;
    west_rd    = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.i_start) begin
          if (k_legal) begin
            k_d        = bus.i_k;
            w_cnt_d    = '0;
            r_cnt_d    = '0;
            w_lane_d   = '0;
            r_lane_d   = '0;
            t_d        = '0;
            overflow_d = 1'b0;
            state_d    = ST_FILL;
          end else begin
            err_d = 1'b1;
          end
        end
        if (bus.i_rx_dv) overflow_d = 1'b1;
      end

      ST_FILL: begin
        if (bus.i_rx_dv && !bus.i_sel) begin
          if (w_full) begin
            overflow_d = 1'b1;
          end else begin
            north_wr = north_sel;
            w_cnt_d  = w_cnt_q + CNT_W'(1);
            w_lane_d = (w_lane_q == NPW'(COL - 1)) ? '0 : w_lane_q + NPW'(1);
          end
        end
        if (bus.i_rx_dv && bus.i_sel) begin
          if (r_full) begin
            overflow_d = 1'b1;
          end else begin
            west_wr  = west_sel;
            r_cnt_d  = r_cnt_q + CNT_W'(1);
            r_lane_d = (r_lane_q == RPW'(ROW - 1)) ? '0 : r_lane_q + RPW'(1);
          end
        end
        if (w_full && r_full) state_d = ST_RUN;
      end

      ST_RUN: begin
        if (bus.i_rx_dv) overflow_d = 1'b1;
        if (!bus.i_stall) begin
          north_rd = north_win;
          west_rd  = west_win;
          if (t_q == t_last) state_d = ST_DONE;
          else               t_d     = t_q + T_W'(1);
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_FILL) || (state_d == ST_RUN);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      k_q        <= '0;
      w_cnt_q    <= '0;
      r_cnt_q    <= '0;
      w_lane_q   <= '0;
      r_lane_q   <= '0;
      t_q        <= '0;
      overflow_q <= 1'b0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      w_cnt_q    <= w_cnt_d;
      r_cnt_q    <= r_cnt_d;
      w_lane_q   <= w_lane_d;
      r_lane_q   <= r_lane_d;
      t_q        <= t_d;
      overflow_q <= overflow_d;
      err_q      <= err_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  for (genvar j = 0; j < COL; j++) begin : g_north
    sa_lane_fifo #(.W_DATA(W_DATA), .W_ADDR(W_ADDR)) u_fifo (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_wr     (north_wr[j]),
      .i_wdata  (bus.i_data),
      .i_rd     (north_rd[j]),
      .o_rdata  (bus.o_north_data[j*W_DATA +: W_DATA]),
      .o_rvalid (bus.o_north_dv[j])
    );
  end

  for (genvar i = 0; i < ROW; i++) begin : g_west
    sa_lane_fifo #(.W_DATA(W_DATA), .W_ADDR(W_ADDR)) u_fifo (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_wr     (west_wr[i]),
      .i_wdata  (bus.i_data),
      .i_rd     (west_rd[i]),
      .o_rdata  (bus.o_west_data[i*W_DATA +: W_DATA]),
      .o_rvalid (bus.o_west_dv[i])
    );
  end

  assign bus.o_busy     = busy_q;
  assign bus.o_done     = done_q;
  assign bus.o_overflow = overflow_q;
  assign bus.o_err      = err_q;

endmodule

// File: tb/tb_sa_skew_feeder.sv
// Directed bench for sa_skew_feeder: a 2x2 instance and a 1-row x 3-column instance.
module tb_sa_skew_feeder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sa_skew_feeder_if #(.ROW(2), .COL(2), .W_DATA(8), .W_ADDR(2)) ifa ();
  sa_skew_feeder_if #(.ROW(1), .COL(3), .W_DATA(8), .W_ADDR(2)) ifb ();

  sa_skew_feeder #(.ROW(2), .COL(2), .W_DATA(8), .W_ADDR(2)) dut_a (
    .i_clk (clk), .i_rst (rst), .bus (ifa)
  );
  sa_skew_feeder #(.ROW(1), .COL(3), .W_DATA(8), .W_ADDR(2)) dut_b (
    .i_clk (clk), .i_rst (rst), .bus (ifb)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] e_ndv [8];
  logic [31:0] e_nd  [8];
  logic [31:0] e_wdv [8];
  logic [31:0] e_wd  [8];
  logic [31:0] e_dn  [8];
  logic [31:0] e_st  [8];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_exp(input int o, input logic [31:0] ndv, input logic [31:0] nd,
                         input logic [31:0] wdv, input logic [31:0] wd,
                         input logic [31:0] dn, input logic [31:0] st);
    e_ndv[o] = ndv; e_nd[o] = nd; e_wdv[o] = wdv; e_wd[o] = wd; e_dn[o] = dn; e_st[o] = st;
  endtask

  task automatic start_a(input int k);
    ifa.i_start = 1'b1; ifa.i_k = 3'(k); tick(); ifa.i_start = 1'b0;
  endtask

  task automatic start_b(input int k);
    ifb.i_start = 1'b1; ifb.i_k = 3'(k); tick(); ifb.i_start = 1'b0;
  endtask

  task automatic send_a(input logic sel, input logic [7:0] d);
    ifa.i_rx_dv = 1'b1; ifa.i_sel = sel; ifa.i_data = d; tick(); ifa.i_rx_dv = 1'b0;
  endtask

  task automatic send_b(input logic sel, input logic [7:0] d);
    ifb.i_rx_dv = 1'b1; ifb.i_sel = sel; ifb.i_data = d; tick(); ifb.i_rx_dv = 1'b0;
  endtask

  // Bounded wait for column 0's first valid.
  task automatic wait_a(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (ifa.o_north_dv[0]) begin ok = 1'b1; break; end
      tick();
    end
    if (!ok) check_eq({tag, " timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_b(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (ifb.o_north_dv[0]) begin ok = 1'b1; break; end
      tick();
    end
    if (!ok) check_eq({tag, " timeout"}, 32'd0, 32'd1);
  endtask

  task automatic run_a(input string tag, input int n);
    for (int o = 0; o < n; o++) begin
      check_eq($sformatf("%s off%0d ndv", tag, o), 32'(ifa.o_north_dv), e_ndv[o]);
      check_eq($sformatf("%s off%0d nd", tag, o), 32'(ifa.o_north_data), e_nd[o]);
      check_eq($sformatf("%s off%0d wdv", tag, o), 32'(ifa.o_west_dv), e_wdv[o]);
      check_eq($sformatf("%s off%0d wd", tag, o), 32'(ifa.o_west_data), e_wd[o]);
      check_eq($sformatf("%s off%0d done", tag, o), 32'(ifa.o_done), e_dn[o]);
      ifa.i_stall = e_st[o][0];
      tick();
    end
    ifa.i_stall = 1'b0;
    check_eq({tag, " post done"}, 32'(ifa.o_done), 32'd0);
    check_eq({tag, " post busy"}, 32'(ifa.o_busy), 32'd0);
  endtask

  task automatic run_b(input string tag, input int n);
    for (int o = 0; o < n; o++) begin
      check_eq($sformatf("%s off%0d ndv", tag, o), 32'(ifb.o_north_dv), e_ndv[o]);
      check_eq($sformatf("%s off%0d nd", tag, o), 32'(ifb.o_north_data), e_nd[o]);
      check_eq($sformatf("%s off%0d wdv", tag, o), 32'(ifb.o_west_dv), e_wdv[o]);
      check_eq($sformatf("%s off%0d wd", tag, o), 32'(ifb.o_west_data), e_wd[o]);
      check_eq($sformatf("%s off%0d done", tag, o), 32'(ifb.o_done), e_dn[o]);
      tick();
    end
    check_eq({tag, " post done"}, 32'(ifb.o_done), 32'd0);
    check_eq({tag, " post busy"}, 32'(ifb.o_busy), 32'd0);
  endtask

  task automatic fill_basic_a(input logic [7:0] base);
    for (int i = 0; i < 8; i++) send_a(i >= 4, base + 8'(i));
  endtask

  task automatic exp_basic();
    set_exp(0, 32'h1, 32'h0001, 32'h1, 32'h0005, 0, 0);
    set_exp(1, 32'h3, 32'h0203, 32'h3, 32'h0607, 0, 0);
    set_exp(2, 32'h2, 32'h0400, 32'h2, 32'h0800, 0, 0);
    set_exp(3, 32'h0, 32'h0000, 32'h0, 32'h0000, 1, 0);
  endtask

  initial begin
    rst = 1'b1;
    ifa.i_start = 1'b0; ifa.i_k = '0; ifa.i_rx_dv = 1'b0; ifa.i_sel = 1'b0;
    ifa.i_data = '0; ifa.i_stall = 1'b0;
    ifb.i_start = 1'b0; ifb.i_k = '0; ifb.i_rx_dv = 1'b0; ifb.i_sel = 1'b0;
    ifb.i_data = '0; ifb.i_stall = 1'b0;
    repeat (3) tick();

    check_eq("rst a ndv", 32'(ifa.o_north_dv), 32'd0);
    check_eq("rst a nd", 32'(ifa.o_north_data), 32'd0);
    check_eq("rst a wdv", 32'(ifa.o_west_dv), 32'd0);
    check_eq("rst a ctl", {28'd0, ifa.o_busy, ifa.o_done, ifa.o_overflow, ifa.o_err}, 32'd0);
    check_eq("rst b ctl", {28'd0, ifb.o_busy, ifb.o_done, ifb.o_overflow, ifb.o_err}, 32'd0);
    rst = 1'b0;
    tick();

    // Basic replay: weights 1..4, data 5..8, K=2.
    start_a(2);
    check_eq("basic busy", 32'(ifa.o_busy), 32'd1);
    fill_basic_a(8'd1);
    wait_a("basic");
    exp_basic();
    run_a("basic", 4);

    // Same job with a 2-cycle stall while t=1.
    start_a(2);
    fill_basic_a(8'd1);
    wait_a("stall");
    set_exp(0, 32'h1, 32'h0001, 32'h1, 32'h0005, 0, 1);
    set_exp(1, 32'h0, 32'h0000, 32'h0, 32'h0000, 0, 1);
    set_exp(2, 32'h0, 32'h0000, 32'h0, 32'h0000, 0, 0);
    set_exp(3, 32'h3, 32'h0203, 32'h3, 32'h0607, 0, 0);
    set_exp(4, 32'h2, 32'h0400, 32'h2, 32'h0800, 0, 0);
    set_exp(5, 32'h0, 32'h0000, 32'h0, 32'h0000, 1, 0);
    run_a("stall", 6);

    // Illegal K values.
    start_a(0);
    check_eq("k0 err", 32'(ifa.o_err), 32'd1);
    check_eq("k0 busy", 32'(ifa.o_busy), 32'd0);
    tick();
    check_eq("k0 err clr", 32'(ifa.o_err), 32'd0);
    start_a(5);
    check_eq("k5 err", 32'(ifa.o_err), 32'd1);
    check_eq("k5 busy", 32'(ifa.o_busy), 32'd0);
    tick();
    check_eq("k5 idle", 32'(ifa.o_busy), 32'd0);

    // Overflow: K=1, third weight byte dropped.
    start_a(1);
    send_a(1'b0, 8'h0A);
    send_a(1'b0, 8'h0B);
    check_eq("ovf pre", 32'(ifa.o_overflow), 32'd0);
    send_a(1'b0, 8'h0C);
    check_eq("ovf set", 32'(ifa.o_overflow), 32'd1);
    send_a(1'b1, 8'h14);
    send_a(1'b1, 8'h15);
    wait_a("ovf");
    set_exp(0, 32'h1, 32'h000A, 32'h1, 32'h0014, 0, 0);
    set_exp(1, 32'h2, 32'h0B00, 32'h2, 32'h1500, 0, 0);
    set_exp(2, 32'h0, 32'h0000, 32'h0, 32'h0000, 1, 0);
    run_a("ovf", 3);
    check_eq("ovf sticky", 32'(ifa.o_overflow), 32'd1);
    start_a(2);
    check_eq("ovf clr", 32'(ifa.o_overflow), 32'd0);

    // Reset at t=1 of a job, then a fresh job.
    fill_basic_a(8'h11);
    wait_a("rstrun");
    rst = 1'b1;
    tick();
    check_eq("rstrun ndv", 32'(ifa.o_north_dv), 32'd0);
    check_eq("rstrun nd", 32'(ifa.o_north_data), 32'd0);
    check_eq("rstrun wdv", 32'(ifa.o_west_dv), 32'd0);
    check_eq("rstrun wd", 32'(ifa.o_west_data), 32'd0);
    check_eq("rstrun ctl", {28'd0, ifa.o_busy, ifa.o_done, ifa.o_overflow, ifa.o_err}, 32'd0);
    rst = 1'b0;
    tick();
    start_a(2);
    fill_basic_a(8'd1);
    wait_a("after rst");
    exp_basic();
    run_a("after rst", 4);

    // 1x3 array, interleaved bytes; RUN waits for the last data byte.
    start_b(2);
    send_b(1'b0, 8'd1);
    send_b(1'b1, 8'h51);
    for (int i = 2; i <= 6; i++) send_b(1'b0, 8'(i));
    repeat (3) tick();
    check_eq("wrap gate ndv", 32'(ifb.o_north_dv), 32'd0);
    check_eq("wrap gate busy", 32'(ifb.o_busy), 32'd1);
    send_b(1'b1, 8'h52);
    wait_b("wrap");
    set_exp(0, 32'h1, 32'h000001, 32'h1, 32'h51, 0, 0);
    set_exp(1, 32'h3, 32'h000204, 32'h1, 32'h52, 0, 0);
    set_exp(2, 32'h6, 32'h030500, 32'h0, 32'h00, 0, 0);
    set_exp(3, 32'h4, 32'h060000, 32'h0, 32'h00, 0, 0);
    set_exp(4, 32'h0, 32'h000000, 32'h0, 32'h00, 1, 0);
    run_b("wrap", 5);
    check_eq("wrap ovf", 32'(ifb.o_overflow), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sa_skew_feeder.md
# sa_skew_feeder

Parametrised successor to the systolic-array input stage. It takes the single UART byte stream, demultiplexes it into per-column weight lanes and per-row data lanes, and then replays every lane with the diagonal (wavefront) skew the systolic array needs. It sits between the UART receiver and the array's north and west edges. Added over the previous stage: synchronous reset, a run-time inner dimension K, a start/done handshake, array back-pressure and overflow/error reporting.

## Interface
Parameters:
- ROW, 4, array rows; number of west lanes.
- COL, 4, array columns; number of north lanes.
- W_DATA, 8, element and byte width.
- W_ADDR, 4, lane FIFO address width; lane depth MAX_K = 2**W_ADDR.

Ports:
- i_clk  in  1  sole clock; all logic is rising-edge.
- i_rst  in  1  synchronous, active-high reset.
- i_start  in  1  one-cycle pulse that begins a job; honoured only in IDLE.
- i_k  in  W_ADDR+1  inner dimension K; sampled on i_start; valid range 1..MAX_K.
- i_rx_dv  in  1  i_data is valid this cycle.
- i_sel  in  1  byte destination: 0 = weight (north), 1 = data (west).
- i_data  in  W_DATA  received byte.
- i_stall  in  1  array back-pressure; freezes replay.
- o_north_data  out  COL*W_DATA  column j occupies bits [j*W_DATA +: W_DATA].
- o_north_dv  out  COL  per-column valid.
- o_west_data  out  ROW*W_DATA  row i occupies bits [i*W_DATA +: W_DATA].
- o_west_dv  out  ROW  per-row valid.
- o_busy  out  1  high in FILL and RUN.
- o_done  out  1  one-cycle pulse at the end of a job.
- o_overflow  out  1  sticky; cleared by i_start or reset.
- o_err  out  1  one-cycle pulse when i_start carries an illegal K.

## Operation
- States are IDLE, FILL, RUN and DONE.
- **IDLE.**
  - i_start with 1 ≤ i_k ≤ MAX_K: latch K, clear counters and o_overflow, go to FILL.
  - i_start with i_k = 0 or i_k > MAX_K: pulse o_err and stay in IDLE.
  - Bytes arriving in IDLE are dropped and set o_overflow.
- **FILL.**
  - A weight byte is written to north lane w_lane. w_lane increments and wraps from COL-1 to 0, and w_cnt increments.
  - Data bytes go to the west lanes the same way, using r_lane and r_cnt (wrap at ROW-1).
  - Consequence: the e-th byte delivered to lane j is element e of that lane.
  - Once w_cnt reaches COL*K, further weight bytes are dropped and set o_overflow. The same applies to data bytes once r_cnt reaches ROW*K.
  - When both counts are complete, go to RUN on the next cycle.
- **RUN.**
  - A step counter t runs from 0 to T_LAST = K + max(ROW,COL) - 2.
  - North lane j is read when j ≤ t ≤ j+K-1. West lane i is read when i ≤ t ≤ i+K-1.
  - While i_stall = 1, t holds and no lane is read.
  - Bytes arriving in RUN are dropped and set o_overflow.
  - After the unstalled step at t = T_LAST, go to DONE.
- **DONE.** o_done = 1 for one cycle, then return to IDLE.
- Lanes that are not valid drive 0 on their data field.
- Counter widths are clog2(max(ROW,COL)*MAX_K + 1). The t counter width covers MAX_K + max(ROW,COL).

## Timing
- Reset values:
  - all outputs 0;
  - state IDLE;
  - all counters and lane pointers 0;
  - all lane FIFOs empty.
- Reset asserted mid-FILL or mid-RUN aborts the job. There is no o_done pulse.
- Lane read latency is 1 cycle: a read issued at step t gives dv and data on the following cycle. A stalled cycle produces dv = 0 on the following cycle.
- Skew: lane j's first valid is exactly j cycles after lane 0's first valid, provided no stall occurs.
- Every lane emits exactly K valids per job.
- o_done asserts the cycle after the last dv cycle.
- FIFO full/empty is unreachable by construction, because per-lane count ≤ K ≤ MAX_K. Verification asserts that no write hits a full lane and no read hits an empty lane.

## Structure
- Shared package sa_feed_pkg holds:
  - the state enum (IDLE, FILL, RUN, DONE);
  - the width-helper constants for counters and t.
- Sub-module sa_lane_fifo implements one synchronous FIFO (depth MAX_K, synchronous reset, registered read data, valid flag). It is instantiated COL + ROW times.
- The top level holds the FSM, the lane demux pointers, the step counter and the skew compare logic.

## Test plan
- **Basic replay.** ROW=COL=2, K=2. Send weights 1,2,3,4 and data 5,6,7,8, then step through RUN.
  - Col0 shows 1 then 3, starting at cycle c. Col1 shows 2 then 4, starting at c+1.
  - Row0 shows 5 then 7 from c. Row1 shows 6 then 8 from c+1.
  - o_done fires at c+3.
- **Stall.** Same job, with i_stall high for 2 cycles at t=1.
  - dv outputs are 0 for those 2 cycles.
  - The sequence resumes intact and o_done is delayed by 2.
- **Overflow.** K=1, COL=2. Send 3 weight bytes.
  - The third byte is dropped and o_overflow = 1.
  - The replay outputs only the first two bytes.
  - A new i_start clears o_overflow.
- **Illegal K.** i_start with i_k=0, then with i_k=MAX_K+1.
  - o_err pulses each time; state stays IDLE and o_busy stays 0.
- **Reset mid-RUN.** Assert i_rst at t=1.
  - Next cycle: all outputs 0 and FIFOs empty.
  - A following job with new bytes replays only the new bytes.
- **Wrap and interleave.** COL=3, ROW=1, K=2, with weight and data bytes interleaved via i_sel.
  - Lane assignment wraps correctly (col0 gets bytes 0,3).
  - The FILL→RUN transition happens only after both totals are reached.
